// File: rtl/mem_access_unit_pkg.sv
// Shared core definitions for the MEM stage: bus widths, lsu_op encodings,
// access sizes and load/store FSM states.
package mem_access_unit_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // lsu_op = inst[25:22]; write-back decodes the same constants
    localparam logic [3:0] LSU_LD_B  = 4'b0000;
    localparam logic [3:0] LSU_LD_H  = 4'b0001;
    localparam logic [3:0] LSU_LD_W  = 4'b0010;
    localparam logic [3:0] LSU_ST_B  = 4'b0100;
    localparam logic [3:0] LSU_ST_H  = 4'b0101;
    localparam logic [3:0] LSU_ST_W  = 4'b0110;
    localparam logic [3:0] LSU_LD_BU = 4'b1000;
    localparam logic [3:0] LSU_LD_HU = 4'b1001;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_CXL_REQ = 3'd4;
    localparam logic [2:0] ST_DISCARD = 3'd5;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [1:0]            size;
        logic                  wr;
        logic [STRB_WIDTH-1:0] wstrb;
        logic [DATA_WIDTH-1:0] wdata;
    } lsu_req_t;

    // Bit 3 marks the unsigned loads, so only 01xx encodings are stores
    function automatic logic lsu_is_store(input logic [3:0] op);
        return op[2] & ~op[3];
    endfunction

endpackage

// File: rtl/mem_access_unit_store_align.sv
// Combinational access-shape generator: size, direction, misalignment,
// byte enables and lane-replicated store data for one lsu_op/address.
module mem_access_unit_store_align
    import mem_access_unit_pkg::*;
(
    input  logic [3:0]            lsu_op,
    input  logic [1:0]            addr_lo,
    input  logic [DATA_WIDTH-1:0] st_data,
    output logic [1:0]            size,
    output logic                  wr,
    output logic                  ale,
    output logic [STRB_WIDTH-1:0] wstrb,
    output logic [DATA_WIDTH-1:0] wdata
);

    always_comb begin
        size  = SIZE_WORD;
        ale   = 1'b0;
        wstrb = 4'b0000;
        wr    = lsu_is_store(lsu_op);
        case (lsu_op[1:0])
            2'b00: begin
                size  = SIZE_BYTE;
                wstrb = 4'b0001 << addr_lo;
            end
            2'b01: begin
                size  = SIZE_HALF;
                ale   = addr_lo[0];
                wstrb = 4'b0011 << addr_lo;
            end
            default: begin
                size  = SIZE_WORD;
                ale   = |addr_lo;
                wstrb = 4'b1111;
            end
        endcase
        if (!wr) begin
            wstrb = 4'b0000;
        end
    end

    // Each byte lane picks the source byte that lands on it for the access size
    for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
        always_comb begin
            case (size)
                SIZE_BYTE: wdata[gi*8 +: 8] = st_data[7:0];
                SIZE_HALF: wdata[gi*8 +: 8] = st_data[(gi % 2)*8 +: 8];
                default:   wdata[gi*8 +: 8] = st_data[gi*8 +: 8];
            endcase
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: one outstanding request on the SRAM-like
// data bus, pipeline stall while busy, and silent absorption of flushed ops.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  mem_op,
    input  logic [3:0]            lsu_op,
    input  logic [ADDR_WIDTH-1:0] vaddr,
    input  logic [DATA_WIDTH-1:0] st_data,
    input  logic                  flush,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [1:0]            data_size,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic [STRB_WIDTH-1:0] data_wstrb,
    output logic [DATA_WIDTH-1:0] data_wdata,
    input  logic                  data_addr_ok,
    input  logic                  data_data_ok,
    input  logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  stall,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  ale
);

    logic [2:0]            state_reg;
    logic [2:0]            state_next;
    lsu_req_t              req_reg;
    lsu_req_t              req_next;
    logic [DATA_WIDTH-1:0] ram_rd_data_reg;
    logic                  align_ale;
    logic                  start;
    logic                  latch_rdata;

    mem_access_unit_store_align u_store_align (
        .lsu_op  (lsu_op),
        .addr_lo (vaddr[1:0]),
        .st_data (st_data),
        .size    (req_next.size),
        .wr      (req_next.wr),
        .ale     (align_ale),
        .wstrb   (req_next.wstrb),
        .wdata   (req_next.wdata)
    );

    assign req_next.addr = vaddr;

    assign ale   = in_valid & mem_op & align_ale;
    assign start = in_valid & mem_op & ~align_ale & ~flush;

    always_comb begin
        state_next  = state_reg;
        latch_rdata = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (data_addr_ok && flush) begin
                    state_next = ST_DISCARD;
                end else if (flush) begin
                    state_next = ST_CXL_REQ;
                end else if (data_addr_ok) begin
                    state_next = ST_WAIT;
                end
            end
            ST_CXL_REQ: begin
                if (data_addr_ok) begin
                    state_next = ST_DISCARD;
                end
            end
            ST_WAIT: begin
                // A flush arriving with the response simply drops it
                if (flush) begin
                    state_next = data_data_ok ? ST_IDLE : ST_DISCARD;
                end else if (data_data_ok) begin
                    state_next  = ST_DONE;
                    latch_rdata = ~req_reg.wr;
                end
            end
            ST_DISCARD: begin
                if (data_data_ok) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            req_reg         <= '0;
            ram_rd_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && start) begin
                req_reg <= req_next;
            end
            if (latch_rdata) begin
                ram_rd_data_reg <= data_rdata;
            end
        end
    end

    // Request stays up through CXL_REQ so a presented request is never withdrawn
    assign data_req    = (state_reg == ST_REQ) || (state_reg == ST_CXL_REQ);
    assign data_wr     = req_reg.wr;
    assign data_size   = req_reg.size;
    assign data_addr   = req_reg.addr;
    assign data_wstrb  = req_reg.wstrb;
    assign data_wdata  = req_reg.wdata;
    assign done        = (state_reg == ST_DONE);
    assign stall       = start & (state_reg != ST_DONE);
    assign ram_rd_data = ram_rd_data_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: the bench plays the data-bus agent
// cycle by cycle and checks outputs against hand-computed values.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, mem_op, flush;
    logic [3:0]  lsu_op;
    logic [31:0] vaddr, st_data;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic        stall, done, ale;
    logic [31:0] ram_rd_data;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .mem_op       (mem_op),
        .lsu_op       (lsu_op),
        .vaddr        (vaddr),
        .st_data      (st_data),
        .flush        (flush),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .stall        (stall),
        .done         (done),
        .ram_rd_data  (ram_rd_data),
        .ale          (ale)
    );

    // Advance to 1ns after the next rising edge; inputs change only here
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd);
        in_valid = 1'b1;
        mem_op   = 1'b1;
        lsu_op   = op;
        vaddr    = addr;
        st_data  = sd;
    endtask

    task automatic idle_inputs();
        in_valid     = 1'b0;
        mem_op       = 1'b0;
        flush        = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        lsu_op = 4'b0000; vaddr = 32'h0; st_data = 32'h0; data_rdata = 32'h0;
        #12;
        vectors++;
        if ({data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata, done, ram_rd_data} !== 72'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got req=%b wr=%b size=%0d addr=%h wstrb=%b wdata=%h done=%b rd=%h exp all zero",
                     data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata, done, ram_rd_data);
        end
        rst_n = 1'b1;
        step();
        vectors++;
        if (stall !== 1'b0 || data_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle got stall=%b req=%b exp 0 0", stall, data_req);
        end
        $display("txn reset: outputs cleared");
    endtask

    task automatic test_load_word();
        issue(4'b0010, 32'h0000_1000, 32'h0);
        data_addr_ok = 1'b1;
        #1;
        vectors++;
        if (stall !== 1'b1 || data_req !== 1'b0) begin
            miscompares++;
            $display("FAIL ldw_c0 got stall=%b req=%b exp 1 0", stall, data_req);
        end
        step(); // cycle 1: REQ
        vectors++;
        if (data_req !== 1'b1 || data_addr !== 32'h1000 || data_size !== 2'd2 || data_wr !== 1'b0 || data_wstrb !== 4'b0000) begin
            miscompares++;
            $display("FAIL ldw_c1 got req=%b addr=%h size=%0d wr=%b wstrb=%b exp 1 00001000 2 0 0000",
                     data_req, data_addr, data_size, data_wr, data_wstrb);
        end
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL ldw_c1_stall got %b exp 1", stall);
        end
        step(); // cycle 2: WAIT
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'hDEAD_BEEF;
        #1;
        vectors++;
        if (data_req !== 1'b0 || stall !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL ldw_c2 got req=%b stall=%b done=%b exp 0 1 0", data_req, stall, done);
        end
        step(); // cycle 3: DONE
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        #1;
        vectors++;
        if (done !== 1'b1 || stall !== 1'b0 || ram_rd_data !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL ldw_c3 got done=%b stall=%b rd=%h exp 1 0 deadbeef", done, stall, ram_rd_data);
        end
        idle_inputs();
        step();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL ldw_c4_done got %b exp 0", done);
        end
        $display("txn LD.W 0x1000 -> rd=%h", ram_rd_data);
    endtask

    task automatic test_store_byte();
        issue(4'b0100, 32'h0000_1003, 32'h0000_00A5);
        data_addr_ok = 1'b1;
        step(); // REQ
        vectors++;
        if (data_req !== 1'b1 || data_wstrb !== 4'b1000 || data_wdata !== 32'hA5A5_A5A5 || data_size !== 2'd0 || data_wr !== 1'b1 || data_addr !== 32'h1003) begin
            miscompares++;
            $display("FAIL stb_req got req=%b wstrb=%b wdata=%h size=%0d wr=%b addr=%h exp 1 1000 a5a5a5a5 0 1 00001003",
                     data_req, data_wstrb, data_wdata, data_size, data_wr, data_addr);
        end
        step(); // WAIT
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'h1234_5678;
        step(); // DONE
        data_data_ok = 1'b0;
        #1;
        vectors++;
        if (done !== 1'b1 || ram_rd_data !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL stb_done got done=%b rd=%h exp 1 deadbeef", done, ram_rd_data);
        end
        idle_inputs();
        step();
        // ST.H at offset 2: upper half lanes, halfword replicated
        issue(4'b0101, 32'h0000_1102, 32'h0000_BEEF);
        data_addr_ok = 1'b1;
        step();
        vectors++;
        if (data_wstrb !== 4'b1100 || data_wdata !== 32'hBEEF_BEEF || data_size !== 2'd1) begin
            miscompares++;
            $display("FAIL sth_req got wstrb=%b wdata=%h size=%0d exp 1100 beefbeef 1", data_wstrb, data_wdata, data_size);
        end
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        step();
        idle_inputs();
        step();
        $display("txn ST.B 0x1003 / ST.H 0x1102 issued");
    endtask

    task automatic test_misaligned();
        issue(4'b0001, 32'h0000_2001, 32'h0);
        data_addr_ok = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (ale !== 1'b1 || stall !== 1'b0 || data_req !== 1'b0) begin
                miscompares++;
                $display("FAIL ldh_ale c%0d got ale=%b stall=%b req=%b exp 1 0 0", c, ale, stall, data_req);
            end
            step();
        end
        lsu_op = 4'b0110; vaddr = 32'h0000_2002;
        #1;
        vectors++;
        if (ale !== 1'b1 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL stw_ale got ale=%b stall=%b exp 1 0", ale, stall);
        end
        lsu_op = 4'b1000; vaddr = 32'h0000_2003;
        #1;
        vectors++;
        if (ale !== 1'b0 || stall !== 1'b1) begin
            miscompares++;
            $display("FAIL ldbu_noale got ale=%b stall=%b exp 0 1", ale, stall);
        end
        idle_inputs();
        step();
        vectors++;
        if (data_req !== 1'b0) begin
            miscompares++;
            $display("FAIL misalign_noreq got req=%b exp 0", data_req);
        end
        $display("txn LD.H 0x2001 -> ale, no request");
    endtask

    task automatic test_flush_cxl();
        issue(4'b0010, 32'h0000_3000, 32'h0);
        step(); // REQ, addr_ok low (1st)
        vectors++;
        if (data_req !== 1'b1) begin
            miscompares++;
            $display("FAIL cxl_c1_req got %b exp 1", data_req);
        end
        step(); // REQ, addr_ok low (2nd), flush
        flush = 1'b1;
        #1;
        vectors++;
        if (data_req !== 1'b1 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL cxl_c2 got req=%b stall=%b exp 1 0", data_req, stall);
        end
        step(); // CXL_REQ, addr_ok low (3rd)
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        vectors++;
        if (data_req !== 1'b1) begin
            miscompares++;
            $display("FAIL cxl_c3_req got %b exp 1", data_req);
        end
        step(); // CXL_REQ, addr_ok arrives
        data_addr_ok = 1'b1;
        #1;
        vectors++;
        if (data_req !== 1'b1) begin
            miscompares++;
            $display("FAIL cxl_c4_req got %b exp 1", data_req);
        end
        step(); // DISCARD; a new op must stall here
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'hBAD0_BAD0;
        issue(4'b0010, 32'h0000_4000, 32'h0);
        #1;
        vectors++;
        if (data_req !== 1'b0 || done !== 1'b0 || stall !== 1'b1) begin
            miscompares++;
            $display("FAIL cxl_discard got req=%b done=%b stall=%b exp 0 0 1", data_req, done, stall);
        end
        step(); // IDLE
        idle_inputs();
        #1;
        vectors++;
        if (done !== 1'b0 || ram_rd_data !== 32'hDEAD_BEEF || data_req !== 1'b0) begin
            miscompares++;
            $display("FAIL cxl_end got done=%b rd=%h req=%b exp 0 deadbeef 0", done, ram_rd_data, data_req);
        end
        step();
        vectors++;
        if (done !== 1'b0 || data_req !== 1'b0) begin
            miscompares++;
            $display("FAIL cxl_quiet got done=%b req=%b exp 0 0", done, data_req);
        end
        $display("txn LD.W 0x3000 flushed in REQ -> absorbed, rd=%h", ram_rd_data);
    endtask

    task automatic test_flush_wait();
        issue(4'b0010, 32'h0000_5000, 32'h0);
        data_addr_ok = 1'b1;
        step(); // REQ
        step(); // WAIT: data_ok with flush
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'h1111_1111;
        flush        = 1'b1;
        step(); // IDLE
        idle_inputs();
        #1;
        vectors++;
        if (done !== 1'b0 || data_req !== 1'b0 || ram_rd_data !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL fw_idle got done=%b req=%b rd=%h exp 0 0 deadbeef", done, data_req, ram_rd_data);
        end
        // LD.BU follows and must go out normally
        issue(4'b1000, 32'h0000_5003, 32'h0);
        data_addr_ok = 1'b1;
        step(); // REQ
        vectors++;
        if (data_req !== 1'b1 || data_addr !== 32'h5003 || data_size !== 2'd0 || data_wr !== 1'b0 || data_wstrb !== 4'b0000) begin
            miscompares++;
            $display("FAIL ldbu_req got req=%b addr=%h size=%0d wr=%b wstrb=%b exp 1 00005003 0 0 0000",
                     data_req, data_addr, data_size, data_wr, data_wstrb);
        end
        step(); // WAIT
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'hC300_0000;
        step(); // DONE
        data_data_ok = 1'b0;
        #1;
        vectors++;
        if (done !== 1'b1 || ram_rd_data !== 32'hC300_0000 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL ldbu_done got done=%b rd=%h stall=%b exp 1 c3000000 0", done, ram_rd_data, stall);
        end
        idle_inputs();
        step();
        $display("txn flush+data_ok in WAIT dropped; LD.BU 0x5003 -> rd=%h", ram_rd_data);
    endtask

    task automatic test_reset_mid();
        issue(4'b0110, 32'h0000_6004, 32'hCAFE_F00D);
        data_addr_ok = 1'b1;
        step(); // REQ
        step(); // WAIT
        data_addr_ok = 1'b0;
        idle_inputs();
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata, done, ram_rd_data} !== 72'h0) begin
            miscompares++;
            $display("FAIL rst_mid got req=%b wr=%b size=%0d addr=%h wstrb=%b wdata=%h done=%b rd=%h exp all zero",
                     data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata, done, ram_rd_data);
        end
        step();
        rst_n = 1'b1;
        data_data_ok = 1'b1;
        step();
        data_data_ok = 1'b0;
        #1;
        vectors++;
        if (done !== 1'b0 || data_req !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_after got done=%b req=%b exp 0 0", done, data_req);
        end
        $display("txn reset in WAIT -> outputs cleared");
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_word();
        test_store_byte();
        test_misaligned();
        test_flush_cxl();
        test_flush_wait();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store initiator: takes the decoded memory op and effective address from EX, issues one request on the SRAM-like data bus, waits for the response, and hands the raw 32-bit read word to write-back. Write-back then does the byte/half shift and sign/zero extension. The unit detects misaligned accesses locally, raises ALE and issues no request for them. It stalls the pipeline while a transaction is outstanding and absorbs responses for flushed transactions.

## Interface
- Parameters: none; widths come from `DATA_WIDTH` and `ADDR_WIDTH` in the shared width header.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  MEM-stage slot holds a valid instruction; held stable while stall=1
- mem_op  in  1  instruction is a load/store
- lsu_op  in  4  inst[25:22]: 0000 LD.B, 0001 LD.H, 0010 LD.W, 0100 ST.B, 0101 ST.H, 0110 ST.W, 1000 LD.BU, 1001 LD.HU
- vaddr  in  32  effective address
- st_data  in  32  store source register
- flush  in  1  pipeline flush (exception/ertn) this cycle
- data_req  out  1  bus request
- data_wr  out  1  1=store
- data_size  out  2  0=byte, 1=half, 2=word
- data_addr  out  32  full byte address, unmodified
- data_wstrb  out  4  byte enables
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response (read data or write ack)
- data_rdata  in  32  raw read word
- stall  out  1  hold MEM and upstream stages
- done  out  1  transaction completed this cycle
- ram_rd_data  out  32  latched raw load word, to write-back
- ale  out  1  misalignment; feeds except_type bit 9

## Operation
- start = in_valid & mem_op & !ale & !flush.
- ale (combinational): for H/HU/ST.H, vaddr[0]; for W/ST.W, |vaddr[1:0]; for byte ops, 0. When ale=1: no request, stall=0.
- Store lanes:
  - B: wstrb = 0001<<vaddr[1:0], wdata = {4{st_data[7:0]}}.
  - H: wstrb = 0011<<vaddr[1:0], wdata = {2{st_data[15:0]}}.
  - W: wstrb = 1111, wdata = st_data.
  - Loads drive wstrb = 0000.
- FSM states IDLE, REQ, WAIT, DONE, CXL_REQ, DISCARD:
  - IDLE: on start, capture addr/size/wr/wstrb/wdata into registers and go to REQ.
  - REQ: data_req=1 from registered fields.
    - addr_ok & !flush: go to WAIT.
    - !addr_ok & flush: go to CXL_REQ; the request is never withdrawn.
    - addr_ok & flush: go to DISCARD.
  - CXL_REQ: data_req held; on addr_ok go to DISCARD.
  - WAIT: on data_ok & !flush, latch rdata (loads only) into ram_rd_data and go to DONE. If flush, go to DISCARD; when data_ok coincides with flush, go to IDLE and drop the data.
  - DISCARD: on data_ok go to IDLE; no done, ram_rd_data unchanged.
  - DONE: done=1 for one cycle, then IDLE.
- stall = start & (state != DONE). A new instruction arriving while the unit is in CXL_REQ/DISCARD stalls until the unit returns to IDLE.
- Only one outstanding transaction at any time.

## Timing
- Reset values: state IDLE; data_req 0; data_wr 0; data_size 0; data_addr 0; data_wstrb 0; data_wdata 0; done 0; ram_rd_data 0.
- Minimum latency with addr_ok=1 and data_ok returned the following cycle:
  - Cycle 0: IDLE, accept.
  - Cycle 1: REQ, addr_ok.
  - Cycle 2: WAIT, data_ok.
  - Cycle 3: DONE, stall=0, ram_rd_data valid.
  - The pipe advances at the end of cycle 3.
- Stores use the same timeline; data_ok is the write acknowledge.
- ram_rd_data holds its value until the next completed load.
- Reset mid-transaction returns the unit to IDLE immediately. The bus agent is reset by the same rst_n.
- flush has priority over completion in every state except DONE; in DONE it has no effect.

## Structure
- Add the lsu_op encodings (LSU_LD_B etc.) and the FSM state enum to the shared core package; WriteBack's op decode reuses the same constants.
- One natural sub-module: lsu_store_align (combinational ale/wstrb/wdata/size generator), also reusable by a future store buffer.

## Test plan
- LD.W at vaddr 0x1000, addr_ok immediate, data_ok one cycle later with 0xDEADBEEF -> done in cycle 3, ram_rd_data=0xDEADBEEF, stall high for cycles 0-2.
- ST.B at 0x1003 with st_data 0x000000A5 -> wstrb=1000, wdata=0xA5A5A5A5, size=0, wr=1.
- LD.H at 0x2001 -> ale=1, data_req never asserted, stall=0.
- LD.W with addr_ok held low 3 cycles, flush in the second cycle -> data_req stays high until addr_ok, then data_ok is absorbed with no done; ram_rd_data keeps its old value.
- Flush coincident with data_ok in WAIT -> unit returns to IDLE next cycle, no done; a following LD.BU issues normally.
- rst_n asserted in WAIT -> all outputs at reset values asynchronously.
